ext_bus_responder: RTL
======================

Name: ext_bus_responder

Overview:
External-side target for the core's memory bus. Decodes ext_n_mreq, ext_n_rd and ext_n_wr from the core's memory controller, plus the core I/O request. It serves byte reads and writes from an on-block RAM window and a single I/O mailbox register. It inserts programmable wait states through n_wait and drives read data back onto the controller's external data input.

Parameters:
MEM_BASE, 16'h1000, first byte address decoded by the RAM window
MEM_AW, 12, RAM address width; window size is 2**MEM_AW bytes
WAIT_STATES, 1, extra wait cycles per memory access (0..15)
IO_PORT, 8'h10, low address byte that selects the mailbox on I/O cycles

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
ext_n_mreq  input  1  memory request, active low
ext_n_rd  input  1  read strobe, active low
ext_n_wr  input  1  write strobe, active low
n_iorq  input  1  I/O request, active low
addr  input  16  bus address
din  input  8  write data from core
dout  output  8  read data to core
n_wait  output  1  wait request to core, active low
mailbox  output  8  mailbox register contents
bus_err  output  1  one-cycle pulse on an illegal or unmapped cycle

Behaviour:
- Reset (async, n_reset low):
  - state IDLE
  - dout 8'hFF
  - n_wait 1
  - mailbox 8'h00
  - bus_err 0
  - RAM contents are not reset.
- All outputs are registered. Inputs share clk with the core, so there are no synchronisers.
- mem_sel: !ext_n_mreq and MEM_BASE <= addr < MEM_BASE + 2**MEM_AW. The comparison uses a 17-bit sum, so there is no wrap past 16'hFFFF.
- io_sel: !n_iorq and addr[7:0] == IO_PORT. ext_n_mreq is ignored on I/O cycles.
- FSM states:
  - IDLE:
    - Start is mem_sel or io_sel with exactly one of ext_n_rd or ext_n_wr low.
    - Memory start: latch addr, din and direction. Issue the RAM read for reads. n_wait<=0, cnt<=WAIT_STATES, go to WAIT.
    - I/O start: complete in one cycle with no wait. Read: dout<=mailbox. Write: mailbox<=din. Go to HOLD.
    - Both strobes low with mem_sel or io_sel: bus_err pulse, stay IDLE.
    - !ext_n_mreq with a strobe low but address outside the window: bus_err pulse, dout<=8'hFF, stay IDLE, n_wait stays 1.
  - WAIT:
    - If cnt != 0, decrement cnt.
    - If cnt == 0, go to ACCESS.
    - n_wait stays low, so it is low for WAIT_STATES+1 cycles in total.
  - ACCESS:
    - Read: dout<=RAM[latched addr - MEM_BASE].
    - Write: RAM[...]<=latched din.
    - n_wait<=1, go to HOLD.
  - HOLD:
    - Stay until ext_n_rd and ext_n_wr are both high, then go to IDLE.
    - dout holds its value. A new cycle is never accepted without a strobe release.
- Abort: if both strobes go high while in WAIT, go to IDLE next cycle.
  - n_wait<=1.
  - No RAM write occurs and dout is unchanged.
- A change of addr or din after the start cycle is ignored; the latched values are used.
- Asserting n_reset mid-cycle forces IDLE immediately and releases n_wait. A RAM write in progress is dropped.

Optional Feature:
- Macro EXT_BUS_STATS_EN.
- When defined, adds ports rd_count[15:0] and wr_count[15:0].
  - Each counts completed memory accesses (ACCESS state) by direction.
  - Counters saturate at 16'hFFFF and reset to 0.
  - I/O, aborted and erroring cycles are not counted.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package z80_bus_pkg:
  - FSM state typedef (IDLE, WAIT, ACCESS, HOLD)
  - default MEM_BASE and IO_PORT constants
  - 8'hFF idle-bus constant
- One sub-module, ext_bus_ram: a single-port synchronous RAM, MEM_AW x 8, one-cycle read, write-enable port.

Test Plan:
1. Write, then read back, with WAIT_STATES=1:
   - Stimulus: write 8'hA5 to 16'h1234, then read 16'h1234.
   - Response: n_wait low for exactly 2 cycles on each access; dout=8'hA5 when n_wait returns high.
2. Window boundaries:
   - Read 16'h0FFF and 16'h2000: bus_err pulses, dout=8'hFF, n_wait never low.
   - Read 16'h1000 and 16'h1FFF: both are accepted.
3. Mailbox I/O:
   - Stimulus: I/O write 8'h3C to port 16'h0010, then I/O read of the same port.
   - Response: mailbox=8'h3C the next cycle; dout=8'h3C; n_wait stays 1.
4. Illegal and aborted cycles:
   - Both strobes low at 16'h1000: bus_err pulses, no state change.
   - Write strobe released during WAIT: returns to IDLE, RAM location unchanged.
5. Reset mid-access:
   - Stimulus: assert n_reset during WAIT.
   - Response: n_wait=1 and dout=8'hFF immediately; the next write/read round-trip is correct.
6. Zero wait states and stats:
   - With WAIT_STATES=0, n_wait is low for 1 cycle.
   - With EXT_BUS_STATS_EN defined: 3 reads and 2 writes give rd_count=3, wr_count=2.
   - With rd_count preloaded to 16'hFFFF by stimulus, it stays at 16'hFFFF.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared definitions for the external bus responder: FSM state encoding,
// default decode constants and the idle-bus value.
package z80_bus_pkg;

  typedef logic [1:0] bus_state_t;

  localparam bus_state_t ST_IDLE   = 2'd0;
  localparam bus_state_t ST_WAIT   = 2'd1;
  localparam bus_state_t ST_ACCESS = 2'd2;
  localparam bus_state_t ST_HOLD   = 2'd3;

  localparam logic [15:0] DEF_MEM_BASE = 16'h1000;
  localparam logic [7:0]  DEF_IO_PORT  = 8'h10;
  localparam logic [7:0]  BUS_IDLE     = 8'hFF;

  // Window test done in 17 bits so a window ending at 16'hFFFF never wraps.
  function automatic logic in_window(input logic [15:0] a,
                                     input logic [15:0] base,
                                     input int unsigned aw);
    logic [16:0] lo;
    logic [16:0] hi;
    lo = {1'b0, base};
    hi = lo + (17'd1 << aw);
    return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ext_bus_ram.sv
// Single-port synchronous byte RAM with one-cycle registered read.
module ext_bus_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // NOTE: the array has no reset branch; clearing a RAM on reset would turn it
  // into thousands of flops instead of a memory macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ext_bus_responder.sv
// External-side target for the core's memory bus: RAM window, I/O mailbox,
// wait-state insertion. Define EXT_BUS_STATS_EN to add rd_count/wr_count.
module ext_bus_responder
  import z80_bus_pkg::*;
#(
  parameter logic [15:0] MEM_BASE    = DEF_MEM_BASE,
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  IO_PORT     = DEF_IO_PORT
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        ext_n_mreq,
  input  logic        ext_n_rd,
  input  logic        ext_n_wr,
  input  logic        n_iorq,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        n_wait,
  output logic [7:0]  mailbox,
  output logic        bus_err
`ifdef EXT_BUS_STATS_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`endif
);

  bus_state_t        state;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] lat_off;
  logic [7:0]        lat_din;
  logic              lat_wr;

  logic              one_strobe;
  logic              both_low;
  logic              any_low;
  logic              released;
  logic              io_hit;
  logic              mem_hit;
  logic              unmapped;
  logic [MEM_AW-1:0] live_off;
  logic [MEM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_rdata;

  assign one_strobe = ext_n_rd ^ ext_n_wr;
  assign both_low   = !ext_n_rd && !ext_n_wr;
  assign any_low    = !ext_n_rd || !ext_n_wr;
  assign released   = ext_n_rd && ext_n_wr;

  // An active n_iorq marks an I/O cycle; ext_n_mreq is then ignored.
  assign io_hit   = !n_iorq && (addr[7:0] == IO_PORT);
  assign mem_hit  = n_iorq && !ext_n_mreq && in_window(addr, MEM_BASE, MEM_AW);
  assign unmapped = n_iorq && !ext_n_mreq && !mem_hit && any_low;

  assign live_off = MEM_AW'(addr - MEM_BASE);

  // The read is issued from the live address in the start cycle, then the
  // latched offset keeps the RAM output stable through WAIT.
  assign ram_addr = (state == ST_IDLE) ? live_off : lat_off;
  assign ram_we   = (state == ST_ACCESS) && lat_wr;

  ext_bus_ram #(.AW(MEM_AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (lat_din),
    .rdata (ram_rdata)
  );

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would leak new values into later statements.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lat_off <= '0;
      lat_din <= '0;
      lat_wr  <= 1'b0;
      dout    <= BUS_IDLE;
      n_wait  <= 1'b1;
      mailbox <= 8'h00;
      bus_err <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (io_hit && one_strobe) begin
            if (!ext_n_rd) begin
              dout <= mailbox;
            end else begin
              mailbox <= din;
            end
            state <= ST_HOLD;
          end else if (mem_hit && one_strobe) begin
            lat_off <= live_off;
            lat_din <= din;
            lat_wr  <= !ext_n_wr;
            cnt     <= 4'(WAIT_STATES);
            n_wait  <= 1'b0;
            state   <= ST_WAIT;
          end else if ((io_hit || mem_hit) && both_low) begin
            bus_err <= 1'b1;
          end else if (unmapped) begin
            bus_err <= 1'b1;
            dout    <= BUS_IDLE;
          end
        end

        ST_WAIT: begin
          if (released) begin
            n_wait <= 1'b1;
            state  <= ST_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Read data lands together with the n_wait release so the core
            // samples valid data on the first cycle it sees n_wait high.
            if (!lat_wr) begin
              dout <= ram_rdata;
            end
            n_wait <= 1'b1;
            state  <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          state <= ST_HOLD;
        end

        ST_HOLD: begin
          if (released) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef EXT_BUS_STATS_EN
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == ST_ACCESS) begin
      if (lat_wr) begin
        wr_count <= sat_inc(wr_count);
      end else begin
        rd_count <= sat_inc(rd_count);
      end
    end
  end
`endif

endmodule
